// File: rtl/tc_ps_gp_bus_rd_fifo.sv
// Read-data stage for the PS GP0 bus region (ADDH_BUS, addr-high 3, addr-low 4).
// Buffers words from the bus receiver in a small FIFO. Each gp0_b4r pulse pops
// one word into a held read-data register for the PS read mux. The stage also
// reports a fill level and sticky overflow/underflow status flags.
//
// Write handshake: a word transfers on a clk edge when wr_vld & wr_rdy are both
// high. wr_rdy is registered, does not depend on wr_vld, and is high whenever
// the FIFO has a free slot. If wr_vld is high while wr_rdy is low, the word is
// dropped and ovf is set. No retry is expected.
module tc_ps_gp_bus_rd_fifo #(
    parameter int          DEPTH      = 16,
    parameter int          AW         = 4,
    parameter logic [31:0] EMPTY_WORD = 32'hDEAD_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [31:0]   wr_data,
    output logic          wr_rdy,
    input  logic          gp0_b4r,
    output logic [31:0]   rd_data,
    output logic          rd_data_vld,
    output logic [AW:0]   fifo_cnt,
    output logic          ovf,
    output logic          udf,
    input  logic          sts_clr
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_next;
    logic          push;
    logic          pop;
    logic          pop_empty;
    logic          push_full;

    // Decode this cycle's accepted push/pop and the error events.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        pop_empty = 1'b0;
        push_full = 1'b0;
        push      = wr_vld & wr_rdy;
        push_full = wr_vld & ~wr_rdy;
        pop       = gp0_b4r & (fifo_cnt != '0);
        pop_empty = gp0_b4r & (fifo_cnt == '0);
    end

    // Next fill level. A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        cnt_next = fifo_cnt;
        if (push && !pop) begin
            cnt_next = fifo_cnt + 1'b1;
        end else if (pop && !push) begin
            cnt_next = fifo_cnt - 1'b1;
        end
    end

    // Storage write. RAM contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, fill level and registered ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            wr_rdy   <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt <= cnt_next;
            wr_rdy   <= (cnt_next != FULL_CNT);
        end
    end

    // Held read word. It updates once per gp0_b4r pulse. A pop on an empty
    // FIFO returns a marker word, and there is no write-through bypass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data     <= '0;
            rd_data_vld <= 1'b0;
        end else begin
            rd_data_vld <= gp0_b4r;
            if (pop) begin
                rd_data <= mem[rd_ptr];
            end else if (pop_empty) begin
                rd_data <= EMPTY_WORD;
            end
        end
    end

    // Sticky status flags. A set event wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (push_full) begin
                ovf <= 1'b1;
            end else if (sts_clr) begin
                ovf <= 1'b0;
            end
            if (pop_empty) begin
                udf <= 1'b1;
            end else if (sts_clr) begin
                udf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tc_ps_gp_bus_rd_fifo.sv
// Directed bench for tc_ps_gp_bus_rd_fifo. A queue-based reference model
// predicts every registered output. A compare process checks those outputs
// each cycle, and literal expectations pin the key points of each scenario.
module tb_tc_ps_gp_bus_rd_fifo;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] EMPTY = 32'hDEAD_0000;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          wr_vld;
    logic [31:0]   wr_data;
    logic          wr_rdy;
    logic          gp0_b4r;
    logic [31:0]   rd_data;
    logic          rd_data_vld;
    logic [AW:0]   fifo_cnt;
    logic          ovf;
    logic          udf;
    logic          sts_clr;

    always #5 clk = ~clk;

    tc_ps_gp_bus_rd_fifo #(.DEPTH(DEPTH), .AW(AW), .EMPTY_WORD(EMPTY)) dut (
        .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .gp0_b4r(gp0_b4r), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
        .fifo_cnt(fifo_cnt), .ovf(ovf), .udf(udf), .sts_clr(sts_clr)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] exp_q[$];
    logic [31:0] m_rd_data;
    logic        m_vld;
    logic        m_ovf;
    logic        m_udf;
    bit          started = 0;

    // Model state is updated from the inputs seen at each rising edge.
    always @(posedge clk) begin
        bit was_empty;
        bit was_full;
        started = 1;
        if (!rst) begin
            exp_q.delete();
            m_rd_data = '0;
            m_vld     = 1'b0;
            m_ovf     = 1'b0;
            m_udf     = 1'b0;
        end else begin
            was_empty = (exp_q.size() == 0);
            was_full  = (exp_q.size() == DEPTH);
            m_vld     = gp0_b4r;
            if (sts_clr) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (gp0_b4r) begin
                if (was_empty) begin
                    m_rd_data = EMPTY;
                    m_udf     = 1'b1;
                end else begin
                    m_rd_data = exp_q.pop_front();
                end
            end
            if (wr_vld) begin
                if (was_full) m_ovf = 1'b1;
                else          exp_q.push_back(wr_data);
            end
        end
    end

    // Compare all outputs each cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("cmp_cnt",   32'(fifo_cnt),    32'(exp_q.size()));
            chk("cmp_rdy",   32'(wr_rdy),      32'(exp_q.size() != DEPTH));
            chk("cmp_vld",   32'(rd_data_vld), 32'(m_vld));
            chk("cmp_data",  rd_data,          m_rd_data);
            chk("cmp_ovf",   32'(ovf),         32'(m_ovf));
            chk("cmp_udf",   32'(udf),         32'(m_udf));
        end
    end

    // ---------------- driver ----------------
    // Drives one cycle of inputs. The task returns at the next falling edge,
    // after the rising edge has sampled those inputs.
    task automatic step(input logic wv, input logic [31:0] wd, input logic p, input logic c);
        wr_vld  = wv;
        wr_data = wd;
        gp0_b4r = p;
        sts_clr = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    logic [31:0] t1_words [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

    initial begin
        rst = 1'b0; wr_vld = 1'b0; wr_data = '0; gp0_b4r = 1'b0; sts_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_cnt", 32'(fifo_cnt), 32'd0);
        chk("reset_rdy", 32'(wr_rdy),   32'd1);
        chk("reset_data", rd_data,      32'd0);
        rst = 1'b1;

        // Basic write of three words, then three spaced pops.
        for (int i = 0; i < 3; i++) step(1'b1, t1_words[i], 1'b0, 1'b0);
        idle(1);
        chk("t1_cnt", 32'(fifo_cnt), 32'd3);
        chk("t1_rdy", 32'(wr_rdy),   32'd1);
        chk("t1_ovf", 32'(ovf),      32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("t1_pop_data", rd_data, t1_words[i]);
            chk("t1_pop_vld",  32'(rd_data_vld), 32'd1);
            idle(1);
            chk("t1_vld_pulse", 32'(rd_data_vld), 32'd0);
            chk("t1_hold",      rd_data, t1_words[i]);
            idle(2);
        end
        chk("t1_end_cnt", 32'(fifo_cnt), 32'd0);

        // Fill to full, overflow, drain, then exercise pointer wrap.
        for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        chk("t2_full_rdy", 32'(wr_rdy),   32'd0);
        chk("t2_full_cnt", 32'(fifo_cnt), 32'd16);
        step(1'b1, 32'h0000_00AA, 1'b0, 1'b0);
        chk("t2_ovf",      32'(ovf),      32'd1);
        chk("t2_ovf_cnt",  32'(fifo_cnt), 32'd16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("t2_drain", rd_data, 32'(i));
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
            chk("t2_wrap", rd_data, 32'h100 + 32'(i));
        end
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t2_ovf_clr", 32'(ovf), 32'd0);

        // Pop while empty.
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t3_empty_data", rd_data, 32'hDEAD_0000);
        chk("t3_empty_vld",  32'(rd_data_vld), 32'd1);
        chk("t3_udf",        32'(udf), 32'd1);
        chk("t3_cnt",        32'(fifo_cnt), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t3_udf_clr", 32'(udf), 32'd0);

        // Push and pop together at empty: underflow, word still stored.
        step(1'b1, 32'h0000_0077, 1'b1, 1'b0);
        chk("t3b_data", rd_data, 32'hDEAD_0000);
        chk("t3b_cnt",  32'(fifo_cnt), 32'd1);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t3b_pop", rd_data, 32'h0000_0077);

        // Push and pop together with five words held.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h0000_0055, 1'b1, 1'b0);
        chk("t4_cnt",  32'(fifo_cnt), 32'd5);
        chk("t4_head", rd_data, 32'h0000_0050);
        for (int i = 1; i < 6; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("t4_order", rd_data, 32'h50 + 32'(i));
        end

        // Overflow set beats clear; push at full with a pop is still rejected.
        for (int i = 0; i < 16; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h0000_00BB, 1'b0, 1'b1);
        chk("t5_ovf_wins", 32'(ovf), 32'd1);
        step(1'b1, 32'h0000_00CC, 1'b1, 1'b0);
        chk("t5_full_pop_cnt",  32'(fifo_cnt), 32'd15);
        chk("t5_full_pop_data", rd_data, 32'h0000_0200);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("t5_drain", rd_data, 32'h200 + 32'(i));
        end

        // Reset in the middle of operation, with a pop pending and a flag set.
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t6_udf_pre", 32'(udf), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        chk("t6_pre_cnt", 32'(fifo_cnt), 32'd7);
        rst = 1'b0;
        step(1'b0, '0, 1'b1, 1'b0);
        rst = 1'b1;
        chk("t6_cnt",  32'(fifo_cnt),    32'd0);
        chk("t6_data", rd_data,          32'd0);
        chk("t6_vld",  32'(rd_data_vld), 32'd0);
        chk("t6_rdy",  32'(wr_rdy),      32'd1);
        chk("t6_ovf",  32'(ovf),         32'd0);
        chk("t6_udf",  32'(udf),         32'd0);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tc_ps_gp_bus_rd_fifo.md
Name: tc_ps_gp_bus_rd_fifo

Overview:
Read-data stage for the PS GP0 bus region: ADDH_BUS, address-high 3, address-low 4. It buffers words from the bus receiver in a small FIFO. On each one-cycle gp0_b4r pulse from the GP read-address decoder, it pops one word into a held read-data register, ready for the PS read mux. It also keeps a fill level and sticky overflow/underflow flags for the status register.

Parameters:
DEPTH, 16, FIFO depth in 32-bit words; power of two, 4..256
AW, 4, pointer width; log2(DEPTH)
EMPTY_WORD, 32'hDEAD_0000, value loaded into rd_data when a pop hits an empty FIFO

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-low reset
wr_vld  in  1  bus receiver word valid
wr_data  in  32  bus receiver word
wr_rdy  out  1  FIFO not full; a write is accepted when wr_vld & wr_rdy
gp0_b4r  in  1  one-cycle pop request from the GP read-address decoder
rd_data  out  32  held read word for the PS read mux
rd_data_vld  out  1  one-cycle pulse when rd_data is updated
fifo_cnt  out  AW+1  current fill level, 0..DEPTH
ovf  out  1  sticky: write attempted while full
udf  out  1  sticky: pop requested while empty
sts_clr  in  1  clears ovf and udf

Behaviour:
- Reset is synchronous: acts on a clk edge with rst==0.
- Reset values:
  - wr_ptr = rd_ptr = 0, fifo_cnt = 0, wr_rdy = 1
  - rd_data = 0, rd_data_vld = 0, ovf = 0, udf = 0
  - Storage RAM contents are don't-care.
- Storage: DEPTH x 32 register/distributed RAM. wr_ptr and rd_ptr are AW bits and wrap naturally from DEPTH-1 to 0. fifo_cnt is tracked separately, AW+1 bits.
- Push: wr_vld & (fifo_cnt != DEPTH).
  - mem[wr_ptr] <= wr_data; wr_ptr++.
- Write while full: data is dropped, pointers and count are unchanged, ovf <= 1.
- Pop: gp0_b4r & (fifo_cnt != 0).
  - rd_data <= mem[rd_ptr]; rd_ptr++; rd_data_vld <= 1 on the next edge.
  - Latency: gp0_b4r high in cycle N gives the new rd_data and rd_data_vld in cycle N+1.
- Pop while empty: rd_data <= EMPTY_WORD, rd_data_vld <= 1, udf <= 1, pointers unchanged.
- Simultaneous push and pop:
  - Both happen and fifo_cnt is unchanged.
  - When fifo_cnt==0, the pop is an underflow (EMPTY_WORD). The pushed word is stored normally. There is no write-through bypass.
  - When fifo_cnt==DEPTH, the pop frees a slot, but the push in the same cycle is still rejected because wr_rdy was 0. ovf is set.
- fifo_cnt updates: +1 on push only, -1 on pop only, otherwise held.
- wr_rdy is registered and equals (fifo_cnt_next != DEPTH).
- rd_data holds its value between pops. rd_data_vld is high for exactly one cycle per gp0_b4r pulse.
- gp0_b4r held high for several cycles pops once per cycle. Each cycle is handled independently.
- Sticky flags: sts_clr clears ovf/udf, but a set event in the same cycle wins, so the flag stays 1.
- Reset mid-operation: all state returns to reset values on the next edge. Any pending pop result is discarded.
- No combinational path exists from any input to any output.

Test Plan:
- Reset, then write 0x11111111, 0x22222222, 0x33333333 -> fifo_cnt=3, wr_rdy=1, ovf=0. Three gp0_b4r pulses 4 cycles apart -> rd_data = 0x11111111, 0x22222222, 0x33333333, each in cycle N+1 with a 1-cycle rd_data_vld; fifo_cnt ends at 0.
- Fill 16 words 0x0..0xF, then one more write 0xAA -> wr_rdy=0 after the 16th, 0xAA dropped, ovf=1, fifo_cnt=16. Drain 16 pops -> 0x0..0xF in order; pointer wrap verified by a further 20 write/pop pairs with the data sequence intact.
- gp0_b4r on an empty FIFO -> rd_data=0xDEAD0000, rd_data_vld=1, udf=1, fifo_cnt=0. sts_clr -> udf=0.
- Push and pop in the same cycle at fifo_cnt=5 -> fifo_cnt stays 5, the popped head is correct, and the new word appears after the existing 4.
- sts_clr asserted in the same cycle as a write-while-full -> ovf remains 1.
- rst=0 for one cycle with fifo_cnt=7 and gp0_b4r asserted -> next cycle fifo_cnt=0, rd_data=0, rd_data_vld=0, wr_rdy=1, flags 0.
